// File: rtl/basket_controller.sv
// basket_controller
//   Shopping-basket sequencer for the sale terminal. Add requests are searched
//   against a small table one entry per cycle, then merged into a matching
//   entry or appended, and finally folded into a running total price.
//   A registered read port exposes one table entry at a time for display.
//
//   Optional feature macro: BASKET_REMOVE_EN
//     When defined, Remove_Pulse subtracts a quantity from an existing entry.
//     An entry that reaches zero is deleted and later entries are shifted
//     down, one per cycle, in the COMPACT state.
//     When undefined, Remove_Pulse is ignored and no subtract logic exists.
module basket_controller #(
    parameter int MAX_ENTRIES = 8,
    parameter int ID_W        = 4,
    parameter int QTY_W       = 4,
    parameter int TOTAL_W     = 16
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               Enable_Pulse,
    input  logic [ID_W-1:0]    ProductID,
    input  logic [QTY_W-1:0]   ProductQuantity,
    input  logic               Clear_Pulse,
    input  logic               Remove_Pulse,
    input  logic [3:0]         Rd_Index,
    output logic [ID_W-1:0]    Rd_ID,
    output logic [QTY_W-1:0]   Rd_Qty,
    output logic [3:0]         EntryCount,
    output logic [TOTAL_W-1:0] TotalPrice,
    output logic               Busy,
    output logic               Ack,
    output logic               Err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEARCH  = 3'd1;
    localparam logic [2:0] S_UPDATE  = 3'd2;
    localparam logic [2:0] S_ACCUM   = 3'd3;
    localparam logic [2:0] S_COMPACT = 3'd4;

    // Largest storable per-entry quantity, one bit wider for sum comparison.
    localparam logic [QTY_W:0] QTY_MAX = {1'b0, {QTY_W{1'b1}}};

    // Unit price table: PRICE(id) = 5*(id+1) for ids 0..11, zero otherwise.
    function automatic logic [TOTAL_W-1:0] price_f(input logic [ID_W-1:0] id);
        logic [TOTAL_W-1:0] p;
        case (id)
            ID_W'(0):  p = TOTAL_W'(5);
            ID_W'(1):  p = TOTAL_W'(10);
            ID_W'(2):  p = TOTAL_W'(15);
            ID_W'(3):  p = TOTAL_W'(20);
            ID_W'(4):  p = TOTAL_W'(25);
            ID_W'(5):  p = TOTAL_W'(30);
            ID_W'(6):  p = TOTAL_W'(35);
            ID_W'(7):  p = TOTAL_W'(40);
            ID_W'(8):  p = TOTAL_W'(45);
            ID_W'(9):  p = TOTAL_W'(50);
            ID_W'(10): p = TOTAL_W'(55);
            ID_W'(11): p = TOTAL_W'(60);
            default:   p = {TOTAL_W{1'b0}};
        endcase
        return p;
    endfunction

    // Basket table
    logic [ID_W-1:0]    tbl_id_r  [MAX_ENTRIES];
    logic [QTY_W-1:0]   tbl_qty_r [MAX_ENTRIES];

    // Control registers and their next values
    logic [2:0]         state_r,   state_n;
    logic [3:0]         idx_r,     idx_n;
    logic [3:0]         count_r,   count_n;
    logic [TOTAL_W-1:0] total_r,   total_n;
    logic [ID_W-1:0]    req_id_r,  req_id_n;
    logic [QTY_W-1:0]   req_qty_r, req_qty_n;
    logic               found_r,   found_n;
    logic               ack_r,     ack_n;
    logic               err_r,     err_n;
    logic               busy_r,    busy_n;
    logic [ID_W-1:0]    rd_id_r;
    logic [QTY_W-1:0]   rd_qty_r;

    // Datapath helpers
    logic [ID_W-1:0]    cur_id_s;
    logic [QTY_W-1:0]   cur_qty_s;
    logic [ID_W-1:0]    rd_id_s;
    logic [QTY_W-1:0]   rd_qty_s;
    logic [QTY_W:0]     sum_s;
    logic [TOTAL_W-1:0] delta_s;
    logic               start_s;
    logic               wr_en_s;
    logic [ID_W-1:0]    wr_id_s;
    logic [QTY_W-1:0]   wr_qty_s;

`ifdef BASKET_REMOVE_EN
    logic               req_rm_r, req_rm_n;
    logic [3:0]         nxt_idx_s;
    logic [ID_W-1:0]    nxt_id_s;
    logic [QTY_W-1:0]   nxt_qty_s;

    assign start_s   = Enable_Pulse | Remove_Pulse;
    assign nxt_idx_s = idx_r + 4'd1;

    // Entry following the current one, source of the compaction shift.
    always_comb begin
        nxt_id_s  = {ID_W{1'b0}};
        nxt_qty_s = {QTY_W{1'b0}};
        for (int e = 0; e < MAX_ENTRIES; e++) begin
            nxt_id_s  = (nxt_idx_s == 4'(e)) ? tbl_id_r[e]  : nxt_id_s;
            nxt_qty_s = (nxt_idx_s == 4'(e)) ? tbl_qty_r[e] : nxt_qty_s;
        end
    end
`else
    logic unused_remove_s;

    assign start_s         = Enable_Pulse;
    assign unused_remove_s = Remove_Pulse;
`endif

    assign sum_s   = {1'b0, cur_qty_s} + {1'b0, req_qty_r};
    assign delta_s = TOTAL_W'(req_qty_r) * price_f(req_id_r);

    // Select the entry under the search/update pointer and the read-port entry.
    always_comb begin
        cur_id_s  = {ID_W{1'b0}};
        cur_qty_s = {QTY_W{1'b0}};
        rd_id_s   = {ID_W{1'b0}};
        rd_qty_s  = {QTY_W{1'b0}};
        for (int e = 0; e < MAX_ENTRIES; e++) begin
            cur_id_s  = (idx_r == 4'(e))    ? tbl_id_r[e]  : cur_id_s;
            cur_qty_s = (idx_r == 4'(e))    ? tbl_qty_r[e] : cur_qty_s;
            rd_id_s   = (Rd_Index == 4'(e)) ? tbl_id_r[e]  : rd_id_s;
            rd_qty_s  = (Rd_Index == 4'(e)) ? tbl_qty_r[e] : rd_qty_s;
        end
    end

    // Sequencer next-state logic; Clear_Pulse overrides every state.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        count_n   = count_r;
        total_n   = total_r;
        req_id_n  = req_id_r;
        req_qty_n = req_qty_r;
        found_n   = found_r;
        ack_n     = 1'b0;
        err_n     = 1'b0;
        busy_n    = busy_r;
        wr_en_s   = 1'b0;
        wr_id_s   = cur_id_s;
        wr_qty_s  = cur_qty_s;
`ifdef BASKET_REMOVE_EN
        req_rm_n  = req_rm_r;
`endif
        if (Clear_Pulse) begin
            state_n = S_IDLE;
            idx_n   = 4'd0;
            count_n = 4'd0;
            total_n = {TOTAL_W{1'b0}};
            busy_n  = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        if ((ProductQuantity == {QTY_W{1'b0}}) || (ProductID >= ID_W'(12))) begin
                            err_n = 1'b1;
                        end else begin
                            req_id_n  = ProductID;
                            req_qty_n = ProductQuantity;
                            idx_n     = 4'd0;
                            state_n   = S_SEARCH;
                            busy_n    = 1'b1;
`ifdef BASKET_REMOVE_EN
                            req_rm_n  = ~Enable_Pulse;
`endif
                        end
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_SEARCH: begin
                    if (idx_r == count_r) begin
                        found_n = 1'b0;
                        state_n = S_UPDATE;
                    end else if (cur_id_s == req_id_r) begin
                        found_n = 1'b1;
                        state_n = S_UPDATE;
                    end else begin
                        idx_n = idx_r + 4'd1;
                    end
                end
                S_UPDATE: begin
`ifdef BASKET_REMOVE_EN
                    if (req_rm_r) begin
                        if (!found_r || (req_qty_r > cur_qty_s)) begin
                            err_n   = 1'b1;
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                        end else if (req_qty_r == cur_qty_s) begin
                            // Last entry is dropped in place; others need shifting.
                            if (idx_r == (count_r - 4'd1)) begin
                                count_n = count_r - 4'd1;
                                state_n = S_ACCUM;
                            end else begin
                                state_n = S_COMPACT;
                            end
                        end else begin
                            wr_en_s  = 1'b1;
                            wr_qty_s = cur_qty_s - req_qty_r;
                            state_n  = S_ACCUM;
                        end
                    end else
`endif
                    begin
                        if (found_r) begin
                            if (sum_s > QTY_MAX) begin
                                err_n   = 1'b1;
                                state_n = S_IDLE;
                                busy_n  = 1'b0;
                            end else begin
                                wr_en_s  = 1'b1;
                                wr_qty_s = sum_s[QTY_W-1:0];
                                state_n  = S_ACCUM;
                            end
                        end else if (count_r == 4'(MAX_ENTRIES)) begin
                            err_n   = 1'b1;
                            state_n = S_IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            wr_en_s  = 1'b1;
                            wr_id_s  = req_id_r;
                            wr_qty_s = req_qty_r;
                            count_n  = count_r + 4'd1;
                            state_n  = S_ACCUM;
                        end
                    end
                end
`ifdef BASKET_REMOVE_EN
                S_COMPACT: begin
                    wr_en_s  = 1'b1;
                    wr_id_s  = nxt_id_s;
                    wr_qty_s = nxt_qty_s;
                    idx_n    = nxt_idx_s;
                    if (nxt_idx_s == (count_r - 4'd1)) begin
                        count_n = count_r - 4'd1;
                        state_n = S_ACCUM;
                    end else begin
                        state_n = S_COMPACT;
                    end
                end
`endif
                S_ACCUM: begin
`ifdef BASKET_REMOVE_EN
                    total_n = req_rm_r ? (total_r - delta_s) : (total_r + delta_s);
`else
                    total_n = total_r + delta_s;
`endif
                    ack_n   = 1'b1;
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
                default: begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and status output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= S_IDLE;
            idx_r     <= 4'd0;
            count_r   <= 4'd0;
            total_r   <= {TOTAL_W{1'b0}};
            req_id_r  <= {ID_W{1'b0}};
            req_qty_r <= {QTY_W{1'b0}};
            found_r   <= 1'b0;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
`ifdef BASKET_REMOVE_EN
            req_rm_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_n;
            idx_r     <= idx_n;
            count_r   <= count_n;
            total_r   <= total_n;
            req_id_r  <= req_id_n;
            req_qty_r <= req_qty_n;
            found_r   <= found_n;
            ack_r     <= ack_n;
            err_r     <= err_n;
            busy_r    <= busy_n;
`ifdef BASKET_REMOVE_EN
            req_rm_r  <= req_rm_n;
`endif
        end
    end

    // Table write port, always at the search/update pointer.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int e = 0; e < MAX_ENTRIES; e++) begin
                tbl_id_r[e]  <= {ID_W{1'b0}};
                tbl_qty_r[e] <= {QTY_W{1'b0}};
            end
        end else if (wr_en_s) begin
            for (int e = 0; e < MAX_ENTRIES; e++) begin
                if (idx_r == 4'(e)) begin
                    tbl_id_r[e]  <= wr_id_s;
                    tbl_qty_r[e] <= wr_qty_s;
                end
            end
        end
    end

    // Registered read port; indices at or past the entry count read as zero.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_id_r  <= {ID_W{1'b0}};
            rd_qty_r <= {QTY_W{1'b0}};
        end else if (Rd_Index < count_r) begin
            rd_id_r  <= rd_id_s;
            rd_qty_r <= rd_qty_s;
        end else begin
            rd_id_r  <= {ID_W{1'b0}};
            rd_qty_r <= {QTY_W{1'b0}};
        end
    end

    assign Rd_ID      = rd_id_r;
    assign Rd_Qty     = rd_qty_r;
    assign EntryCount = count_r;
    assign TotalPrice = total_r;
    assign Busy       = busy_r;
    assign Ack        = ack_r;
    assign Err        = err_r;

endmodule
